// File: rtl/bcd_count_sequencer.sv
// Run-control sequencer for a cascade of BCD digit counters: start/stop/clear
// command handling, ripple-carry digit increment, terminal-count and rollover pulses.
module bcd_count_sequencer #(
    parameter int DIGITS      = 4,
    parameter int AUTO_RELOAD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  tick,
    input  logic [4*DIGITS-1:0]   target,
    output logic [4*DIGITS-1:0]   count,
    output logic [1:0]            state,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t              cur, state_d;
    logic [4*DIGITS-1:0] cnt_q, cnt_d, inc;
    logic [DIGITS:0]     carry;
    logic                all9, hit;
    logic                done_d, wrap_d;

    // carry[i] is set when every digit below i is 9, so the whole chain updates in one edge
    always_comb begin
        carry[0] = 1'b1;
        inc      = cnt_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry[i])
                inc[4*i +: 4] = (cnt_q[4*i +: 4] == 4'd9) ? 4'd0 : cnt_q[4*i +: 4] + 4'd1;
            carry[i+1] = carry[i] & (cnt_q[4*i +: 4] == 4'd9);
        end
        all9 = carry[DIGITS];
        hit  = (inc == target);
    end

    always_comb begin
        state_d = cur;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        case (cur)
            IDLE: begin
                if (clear)      cnt_d   = '0;
                else if (start) state_d = RUN;
            end
            RUN: begin
                if (clear) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (stop) begin
                    state_d = HOLD;
                end else if (tick) begin
                    wrap_d = all9;
                    cnt_d  = inc;
                    if (hit) begin
                        done_d = 1'b1;
                        if (AUTO_RELOAD != 0) cnt_d   = '0;
                        else                  state_d = DONE;
                    end
                end
            end
            HOLD: begin
                if (clear) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (clear) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur   <= IDLE;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            cur   <= state_d;
            cnt_q <= cnt_d;
            busy  <= (state_d == RUN);
            done  <= done_d;
            wrap  <= wrap_d;
        end
    end

    assign count = cnt_q;
    assign state = cur;

endmodule
